fifo_rd_fwft: RTL and testbench

- Read-domain output stage of the dual-clock FIFO, directly downstream of the read-pointer/empty block and the dual-port RAM read port.
- Converts the pop-style interface (rinc/rempty/rdata) into a first-word-fall-through valid/ready stream.
- Uses a small prefetch buffer with credit accounting so RAM read latency costs no throughput.

---
 rtl/fifo_rd_fwft.sv | 92 +++++++++
 tb/tb_fifo_rd_fwft.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_fwft.sv
// Read-side FWFT output stage: turns the pop interface (rinc/rempty/rdata) into a valid/ready stream.
// Optional synchronous flush port enabled by defining FWFT_FLUSH_EN.
module fifo_rd_fwft #(
    parameter int DSIZE      = 8,
    parameter int BUF_DEPTH  = 2,
    parameter int RD_LATENCY = 1
) (
    input  logic                           rclk,
    input  logic                           rrst_n,
    input  logic                           rempty,
    output logic                           rinc,
    input  logic [DSIZE-1:0]               rdata,
`ifdef FWFT_FLUSH_EN
    input  logic                           flush,
`endif
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DSIZE-1:0]               out_data,
    output logic [$clog2(BUF_DEPTH+1)-1:0] level
);
    localparam int LW  = $clog2(BUF_DEPTH + 1);
    localparam int LW1 = LW + 1;
    localparam int PW  = $clog2(BUF_DEPTH);
    localparam logic [LW:0]   DEPTH_C  = LW1'(BUF_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(BUF_DEPTH - 1);

    logic [DSIZE-1:0] mem [BUF_DEPTH];
    logic [PW-1:0]    head, tail;
    logic [LW-1:0]    occ;
    logic             inflight, arrive, deq, wr_en, flush_i;
    logic [LW:0]      committed;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Credits count both stored and in-flight words, net of the word leaving this cycle.
    assign deq       = out_valid & out_ready;
    assign committed = {1'b0, occ} + {{LW{1'b0}}, inflight} - {{LW{1'b0}}, deq};
    assign rinc      = rrst_n & ~rempty & ~flush_i & (committed < DEPTH_C);

    generate
        if (RD_LATENCY == 0) begin : g_lat0
            assign inflight = 1'b0;
            assign arrive   = rinc;
        end else begin : g_lat1
            logic inflight_q;
            always_ff @(posedge rclk or negedge rrst_n) begin
                if (!rrst_n) inflight_q <= 1'b0;
                else         inflight_q <= rinc;
            end
            assign inflight = inflight_q;
            assign arrive   = inflight_q;
        end
    endgenerate

`ifdef FWFT_FLUSH_EN
    // A word landing during flush belongs to the discarded stream.
    logic discard;
    assign flush_i = flush;
    assign discard = flush & arrive;
    assign wr_en   = arrive & ~discard;
`else
    assign flush_i = 1'b0;
    assign wr_en   = arrive;
`endif

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
        end else if (flush_i) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (wr_en) begin
                mem[tail] <= rdata;
                tail      <= ptr_inc(tail);
            end
            if (deq) head <= ptr_inc(head);
            occ <= occ + LW'(wr_en) - LW'(deq);
        end
    end

    assign out_valid = (occ != '0);
    assign out_data  = mem[head];
    assign level     = occ;

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// Directed bench for fifo_rd_fwft: two instances (BUF_DEPTH 2 and 3) share stimulus, each with a RAM model and queue scoreboard.
module tb_fifo_rd_fwft;
    logic clk = 1'b0;
    logic rrst_n;
    logic out_ready;
    logic force_empty;
    int   avail;
`ifdef FWFT_FLUSH_EN
    logic flush;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] dval(input int k);
        return 8'(17 * (k + 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int DEPTH = (g == 0) ? 2 : 3;
        logic       rempty, rinc, out_valid;
        logic [7:0] rdata, out_data;
        logic [1:0] level;
        int         ptr;
        int         pops = 0;
        int         rx = 0;
        logic       inf = 1'b0;
        logic [7:0] inf_data = '0;
        logic [7:0] q[$];

        assign rempty = force_empty | (ptr >= avail);

        fifo_rd_fwft #(.DSIZE(8), .BUF_DEPTH(DEPTH), .RD_LATENCY(1)) u_dut (
            .rclk      (clk),
            .rrst_n    (rrst_n),
            .rempty    (rempty),
            .rinc      (rinc),
            .rdata     (rdata),
`ifdef FWFT_FLUSH_EN
            .flush     (flush),
`endif
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_data),
            .level     (level)
        );

        // RAM read port with one cycle of latency; pointer shares the reset
        always @(posedge clk or negedge rrst_n) begin
            if (!rrst_n) begin
                ptr   <= 0;
                rdata <= '0;
            end else if (rinc) begin
                rdata <= dval(ptr);
                ptr   <= ptr + 1;
            end
        end

        always @(negedge clk) begin
            if (!rrst_n) begin
                q.delete();
                inf <= 1'b0;
            end else begin
                chk($sformatf("g%0d_level", g), 32'(level), 32'(q.size()));
                chk($sformatf("g%0d_valid", g), 32'(out_valid), 32'(q.size() != 0));
                if (q.size() != 0) chk($sformatf("g%0d_data", g), 32'(out_data), 32'(q[0]));
                chk($sformatf("g%0d_rinc_empty", g), 32'(rinc & rempty), 32'd0);
                chk($sformatf("g%0d_level_bound", g), 32'(32'(level) > DEPTH), 32'd0);
`ifdef FWFT_FLUSH_EN
                if (flush) begin
                    chk($sformatf("g%0d_rinc_flush", g), 32'(rinc), 32'd0);
                    q.delete();
                    inf <= 1'b0;
                end else
`endif
                begin
                    if (out_valid && out_ready && q.size() != 0) begin
                        void'(q.pop_front());
                        rx <= rx + 1;
                    end
                    if (inf) q.push_back(inf_data);
                    inf      <= rinc;
                    inf_data <= dval(ptr);
                end
                if (rinc) pops <= pops + 1;
            end
        end
    end

    initial begin
        int start0, start1, cnt0, cnt1;
        logic done;
        logic [7:0] exp0, exp1;

        rrst_n = 1'b1; out_ready = 1'b0; force_empty = 1'b1; avail = 0;
`ifdef FWFT_FLUSH_EN
        flush = 1'b0;
`endif
        #1;
        rrst_n = 1'b0; force_empty = 1'b0; avail = 3; out_ready = 1'b1;
        #2;
        chk("rst_rinc", 32'(g_inst[0].rinc), 32'd0);
        chk("rst_valid", 32'(g_inst[0].out_valid), 32'd0);
        chk("rst_level", 32'(g_inst[0].level), 32'd0);
        chk("rst_data", 32'(g_inst[0].out_data), 32'd0);
        chk("rst_valid_g1", 32'(g_inst[1].out_valid), 32'd0);

        // three words, out_ready high: first word two cycles after release
        repeat (2) @(posedge clk);
        #1 rrst_n = 1'b1;
        @(negedge clk);
        chk("first_rinc", 32'(g_inst[0].rinc), 32'd1);
        chk("first_valid_c0", 32'(g_inst[0].out_valid), 32'd0);
        @(negedge clk);
        chk("first_valid_c1", 32'(g_inst[0].out_valid), 32'd0);
        @(negedge clk);
        chk("w0_valid", 32'(g_inst[0].out_valid), 32'd1);
        chk("w0_data", 32'(g_inst[0].out_data), 32'h11);
        chk("w0_data_g1", 32'(g_inst[1].out_data), 32'h11);
        @(negedge clk);
        chk("w1_data", 32'(g_inst[0].out_data), 32'h22);
        @(negedge clk);
        chk("w2_data", 32'(g_inst[0].out_data), 32'h33);
        @(negedge clk);
        chk("drained_valid", 32'(g_inst[0].out_valid), 32'd0);
        chk("pops3_g0", 32'(g_inst[0].pops), 32'd3);
        chk("pops3_g1", 32'(g_inst[1].pops), 32'd3);

        // stall: buffer fills to depth, then pops stop
        @(posedge clk); #1;
        avail = 100000; out_ready = 1'b0;
        repeat (6) @(negedge clk);
        chk("stall_level_g0", 32'(g_inst[0].level), 32'd2);
        chk("stall_level_g1", 32'(g_inst[1].level), 32'd3);
        chk("stall_rinc_g0", 32'(g_inst[0].rinc), 32'd0);
        chk("stall_rinc_g1", 32'(g_inst[1].rinc), 32'd0);
        chk("stall_pops_g0", 32'(g_inst[0].pops), 32'd5);
        chk("stall_pops_g1", 32'(g_inst[1].pops), 32'd6);
        repeat (3) begin
            @(negedge clk);
            chk("stall_data_g0", 32'(g_inst[0].out_data), 32'h44);
            chk("stall_data_g1", 32'(g_inst[1].out_data), 32'h44);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("resume_rinc_g0", 32'(g_inst[0].rinc), 32'd1);
        chk("resume_rinc_g1", 32'(g_inst[1].rinc), 32'd1);

        // steady state: one word per cycle
        repeat (20) @(negedge clk);
        cnt0 = 0; cnt1 = 0;
        repeat (100) begin
            @(negedge clk);
            if (g_inst[0].out_valid) cnt0++;
            if (g_inst[1].out_valid) cnt1++;
        end
        chk("thru_g0", 32'(cnt0), 32'd100);
        chk("thru_g1", 32'(cnt1), 32'd100);

        // rempty toggling every cycle with random out_ready, 1000 words each
        @(posedge clk); #1;
        start0 = g_inst[0].rx; start1 = g_inst[1].rx;
        done = 1'b0;
        for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
            force_empty = ~force_empty;
            out_ready   = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            done = (g_inst[0].rx >= start0 + 1000) && (g_inst[1].rx >= start1 + 1000);
        end
        chk("random_done", 32'(done), 32'd1);
        force_empty = 1'b1; out_ready = 1'b1;
        repeat (8) @(posedge clk); #1;

        // reset while holding two words (g1 also has one in flight)
        out_ready = 1'b0; force_empty = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("pre_rst_level_g0", 32'(g_inst[0].level), 32'd2);
        chk("pre_rst_level_g1", 32'(g_inst[1].level), 32'd2);
        rrst_n = 1'b0;
        #1;
        chk("mid_rst_valid_g0", 32'(g_inst[0].out_valid), 32'd0);
        chk("mid_rst_level_g0", 32'(g_inst[0].level), 32'd0);
        chk("mid_rst_valid_g1", 32'(g_inst[1].out_valid), 32'd0);
        chk("mid_rst_level_g1", 32'(g_inst[1].level), 32'd0);
        chk("mid_rst_rinc", 32'(g_inst[0].rinc), 32'd0);
        @(posedge clk); #1;
        rrst_n = 1'b1; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_valid", 32'(g_inst[0].out_valid), 32'd1);
        chk("post_rst_data_g0", 32'(g_inst[0].out_data), 32'h11);
        chk("post_rst_data_g1", 32'(g_inst[1].out_data), 32'h11);

`ifdef FWFT_FLUSH_EN
        // flush with one word stored and one arriving
        @(posedge clk); #1;
        force_empty = 1'b1;
        repeat (8) @(posedge clk); #1;
        out_ready = 1'b0; force_empty = 1'b0;
        repeat (2) @(posedge clk); #1;
        flush = 1'b1; force_empty = 1'b1;
        @(negedge clk);
        chk("flush_pre_level", 32'(g_inst[0].level), 32'd1);
        chk("flush_rinc", 32'(g_inst[0].rinc), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_valid_g0", 32'(g_inst[0].out_valid), 32'd0);
        chk("flush_level_g0", 32'(g_inst[0].level), 32'd0);
        chk("flush_valid_g1", 32'(g_inst[1].out_valid), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("flush_hold_valid", 32'(g_inst[0].out_valid), 32'd0);
        end
        @(posedge clk); #1;
        exp0 = dval(g_inst[0].ptr);
        exp1 = dval(g_inst[1].ptr);
        out_ready = 1'b1; force_empty = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_flush_valid", 32'(g_inst[0].out_valid), 32'd1);
        chk("post_flush_data_g0", 32'(g_inst[0].out_data), 32'(exp0));
        chk("post_flush_data_g1", 32'(g_inst[1].out_data), 32'(exp1));
`endif

        @(posedge clk); #1;
        force_empty = 1'b1;
        repeat (6) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
